// File: rtl/sw_field_reg.sv
//==============================================================================
// Module      : sw_field_reg
// Description : One register field with sw read/write side effects, hw load,
//               write-once lock, pulse mode and optional event counter.
//               Optional parity checking: define SW_FIELD_REG_PARITY_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

`ifndef SW_RO
`define SW_RO  0
`define SW_RW  1
`define SW_WO  2
`define SW_RW1 3
`define SW_W1  4
`endif
`ifndef NA
`define NA     0
`endif
`ifndef RCLR
`define RCLR   1
`define RSET   2
`endif
`ifndef WOCLR
`define WOCLR  1
`define WOSET  2
`define WOT    3
`define WZS    4
`define WZC    5
`define WZT    6
`endif

module sw_field_reg #(
    parameter int                 F_WIDTH      = 4,
    parameter int                 SW_CNT       = 1,
    parameter logic [F_WIDTH-1:0] RESET_VAL    = '0,
    parameter int                 SW_TYPE      = `SW_RW,
    parameter int                 ONREAD_TYPE  = `NA,
    parameter int                 ONWRITE_TYPE = `NA,
    parameter bit                 PULSE        = 1'b0,
    parameter bit                 COUNTER      = 1'b0,
    parameter bit                 CNT_SAT      = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [SW_CNT-1:0]           sw_wr,
    input  logic [SW_CNT-1:0]           sw_rd,
    input  logic [F_WIDTH*SW_CNT-1:0]   sw_wr_data,
    input  logic                        hw_we,
    input  logic [F_WIDTH-1:0]          hw_wdata,
    input  logic                        hw_incr,
    output logic [F_WIDTH-1:0]          field_value,
    output logic                        swmod_out,
    output logic                        swacc_out,
    output logic                        cnt_ovf,
    output logic                        parity_err
);

    localparam logic [F_WIDTH-1:0] ONES = '1;
    localparam bit SW_WRITABLE = (SW_TYPE != `SW_RO);
    localparam bit SW_READABLE = (SW_TYPE == `SW_RO) || (SW_TYPE == `SW_RW) || (SW_TYPE == `SW_RW1);
    localparam bit WRITE_ONCE  = (SW_TYPE == `SW_RW1) || (SW_TYPE == `SW_W1);

    generate
        if (F_WIDTH < 1 || F_WIDTH > 64 || SW_CNT < 1) begin : g_bad_size
            $fatal(1, "sw_field_reg: F_WIDTH must be 1..64 and SW_CNT >= 1");
        end
        if (SW_TYPE < `SW_RO || SW_TYPE > `SW_W1) begin : g_bad_sw_type
            $fatal(1, "sw_field_reg: illegal SW_TYPE");
        end
        if (ONREAD_TYPE < `NA || ONREAD_TYPE > `RSET) begin : g_bad_onread
            $fatal(1, "sw_field_reg: illegal ONREAD_TYPE");
        end
        if (ONWRITE_TYPE < `NA || ONWRITE_TYPE > `WZT) begin : g_bad_onwrite
            $fatal(1, "sw_field_reg: illegal ONWRITE_TYPE");
        end
    endgenerate

    logic [F_WIDTH-1:0] field_q, field_d;
    logic               lock_q, lock_d;
    logic               swmod_q, swmod_d;
    logic               swacc_q;
    logic               ovf_q, ovf_d;

    logic [F_WIDTH-1:0] wr_data;
    logic [F_WIDTH-1:0] wr_val;
    logic [F_WIDTH-1:0] hold_val;
    logic               wr_accept;
    logic               rd_effect;

    // Scan from the top so the lowest-index active channel is the last to assign.
    always_comb begin
        wr_data = '0;
        for (int i = SW_CNT - 1; i >= 0; i--) begin
            if (sw_wr[i]) wr_data = sw_wr_data[i*F_WIDTH +: F_WIDTH];
        end
    end

    assign wr_accept = SW_WRITABLE && (|sw_wr) && !(WRITE_ONCE && lock_q);
    assign rd_effect = SW_READABLE && (ONREAD_TYPE != `NA) && (|sw_rd);

    // In pulse mode the idle value is zero, so earlier pulses never leak into a new write.
    assign hold_val = PULSE ? '0 : field_q;

    always_comb begin
        case (ONWRITE_TYPE)
            `WOCLR:  wr_val = hold_val & ~wr_data;
            `WOSET:  wr_val = hold_val | wr_data;
            `WOT:    wr_val = hold_val ^ wr_data;
            `WZS:    wr_val = hold_val | ~wr_data;
            `WZC:    wr_val = hold_val & wr_data;
            `WZT:    wr_val = hold_val ^ ~wr_data;
            default: wr_val = wr_data;
        endcase
    end

    always_comb begin
        field_d = hold_val;
        lock_d  = lock_q;
        swmod_d = 1'b0;
        ovf_d   = 1'b0;
        if (wr_accept) begin
            field_d = wr_val;
            lock_d  = lock_q | WRITE_ONCE;
            swmod_d = 1'b1;
        end else if (rd_effect) begin
            field_d = (ONREAD_TYPE == `RSET) ? ONES : '0;
            swmod_d = 1'b1;
        end else if (hw_we) begin
            field_d = hw_wdata;
        end else if (COUNTER && hw_incr) begin
            if (field_q == ONES) begin
                field_d = CNT_SAT ? ONES : '0;
                ovf_d   = 1'b1;
            end else begin
                field_d = field_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            field_q <= RESET_VAL;
            lock_q  <= 1'b0;
            swmod_q <= 1'b0;
            swacc_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            field_q <= field_d;
            lock_q  <= lock_d;
            swmod_q <= swmod_d;
            swacc_q <= (|sw_rd) | (|sw_wr);
            ovf_q   <= ovf_d;
        end
    end

    assign field_value = field_q;
    assign swmod_out   = swmod_q;
    assign swacc_out   = swacc_q;
    assign cnt_ovf     = ovf_q;

`ifdef SW_FIELD_REG_PARITY_EN
    logic par_q;
    logic perr_q;

    // Parity tracks the intended next value; any later divergence of the flops is caught.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_q  <= ^RESET_VAL;
            perr_q <= 1'b0;
        end else begin
            par_q <= ^field_d;
            if ((^field_q) != par_q) perr_q <= 1'b1;
        end
    end

    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

`default_nettype wire
